// File: rtl/counter_reader.sv
// Sweeps the five FIFO pop counters one index at a time and keeps a local copy
// of each count. A sweep stops early if IDLE drops, and a read that gets no answer is stored as 0.
module counter_reader #(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       IDLE,
    input  logic       start,
    input  logic       valid,
    input  logic [4:0] data_out,
    output logic       req,
    output logic [2:0] idx,
    output logic [4:0] cnt0,
    output logic [4:0] cnt1,
    output logic [4:0] cnt2,
    output logic [4:0] cnt3,
    output logic [4:0] cnt4,
    output logic       busy,
    output logic       done,
    output logic       abort,
    output logic       err_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer;
    logic [4:0][4:0] cnt;
    logic            go, cap, tmo, abort_n;
    logic [4:0]      cap_val;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        go      = 1'b0;
        cap     = 1'b0;
        cap_val = data_out;
        tmo     = 1'b0;
        abort_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && IDLE) begin
                    go      = 1'b1;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (!IDLE) begin
                    abort_n = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                // Losing IDLE beats a response that arrives in the same cycle
                if (!IDLE) begin
                    abort_n = 1'b1;
                    state_n = S_IDLE;
                end else if (valid || timer == TW'(TIMEOUT - 1)) begin
                    cap     = 1'b1;
                    tmo     = !valid;
                    cap_val = valid ? data_out : 5'd0;
                    state_n = (idx == 3'd4) ? S_DONE : S_REQ;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            idx         <= '0;
            timer       <= '0;
            abort       <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            abort <= abort_n;
            if (tmo) err_timeout <= 1'b1;
            case (state)
                S_IDLE: if (go) idx <= '0;
                S_REQ:  timer <= '0;
                S_WAIT: begin
                    if (cap && idx != 3'd4)  idx   <= idx + 3'd1;
                    else if (!cap && !abort_n) timer <= timer + 1'b1;
                end
                S_DONE: idx <= '0;
                default: ;
            endcase
            if (abort_n) idx <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < 5; i++)
                if (cap && idx == 3'(i)) cnt[i] <= cap_val;
        end
    end

    assign req  = (state == S_REQ);
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];
    assign cnt4 = cnt[4];

endmodule
